pwm_capture: RTL and testbench

- Downstream consumer of the N-bit PWM generator.
- Samples a PWM waveform with the system clock and measures its high time and period in clock cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a constant (0%/100%) or stalled input as overflow and exposes the current line level.
- Used for loopback self-check of the PWM stage and for decoding external PWM inputs.

---
 rtl/pwm_capture_pkg.sv | 16 +
 rtl/pwm_capture_if.sv | 35 +++
 rtl/pwm_capture_sync.sv | 66 ++++++
 rtl/pwm_capture.sv | 96 +++++++++
 tb/tb_pwm_capture.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared FSM encoding, default widths and saturation value for the PWM capture block.
// Included first so the interface, synchronizer and top all agree on CW and the state encoding.
package pwm_capture_pkg;

  localparam int CW_DEF   = 9;
  localparam int SYNC_DEF = 2;

  // All-ones terminal count for the default counter width
  localparam logic [CW_DEF-1:0] SAT_DEF = {CW_DEF{1'b1}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: enable/waveform inputs and measurement results of pwm_capture.
// master = capture block (drives results), slave = consumer (drives en and the waveform).
interface pwm_capture_if #(
  parameter int CW = pwm_capture_pkg::CW_DEF
);

  logic          en;
  logic          pwm_in;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic          valid;
  logic          overflow;
  logic          level;

  modport master (
    input  en,
    input  pwm_in,
    output high_cnt,
    output period_cnt,
    output valid,
    output overflow,
    output level
  );

  modport slave (
    output en,
    output pwm_in,
    input  high_cnt,
    input  period_cnt,
    input  valid,
    input  overflow,
    input  level
  );

endinterface

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: SYNC-deep synchronizer, optional 3-sample stability filter (PWM_CAPTURE_GLITCH_FILTER_EN), edge detect.
// Latency: SYNC cycles to level, +2 with the filter; no backpressure, outputs follow the line every cycle.
module pwm_capture_sync
  import pwm_capture_pkg::*;
#(
  parameter int SYNC = SYNC_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC-1:0] sync_q;
  logic            raw;
  logic            s;
  logic            s_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], din};
    end
  end

  assign raw = sync_q[SYNC-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic f1_q;
  logic f2_q;
  logic s_q;

  // s only moves once three consecutive synchronized samples agree
  assign s = ((raw == f1_q) && (f1_q == f2_q)) ? raw : s_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      f1_q <= 1'b0;
      f2_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      f1_q <= raw;
      f2_q <= f1_q;
      s_q  <= s;
    end
  end
`else
  assign s = raw;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  assign level = s;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and period in clk cycles; results + valid at edge SYNC+1 after the first high sample (+2 with PWM_CAPTURE_GLITCH_FILTER_EN).
// No backpressure: valid is a one-cycle strobe and the consumer must take it; overflow is sticky until the next valid.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic clk,
  input  logic clr_n,
  pwm_capture_if.master bus
);

  localparam logic [CW-1:0] SAT = {CW{1'b1}};

  logic          rise;
  logic          fall;
  logic          level_w;
  state_e        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hi_lat;
  logic [CW-1:0] high_q;
  logic [CW-1:0] period_q;
  logic          valid_q;
  logic          overflow_q;

  pwm_capture_sync #(
    .SYNC (SYNC)
  ) u_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .din   (bus.pwm_in),
    .rise  (rise),
    .fall  (fall),
    .level (level_w)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (!bus.en) begin
      // Results and overflow hold while disabled; the next rise only re-aligns
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (rise) begin
        cnt <= CW'(1);
      end else if (cnt != SAT) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
          end else if (cnt == SAT) begin
            overflow_q <= 1'b1;
          end
        end
        MEASURE: begin
          // A rise landing on the saturation cycle is still a valid period
          if (rise) begin
            high_q     <= hi_lat;
            period_q   <= cnt;
            valid_q    <= 1'b1;
            overflow_q <= 1'b0;
          end else if (cnt == SAT) begin
            overflow_q <= 1'b1;
            state      <= IDLE;
          end else if (fall) begin
            hi_lat <= cnt;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.high_cnt   = high_q;
  assign bus.period_cnt = period_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.level      = level_w;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed clock-aligned PWM stimulus with a small expected-measurement queue.
module tb_pwm_capture;

  localparam int CW   = 9;
  localparam int SYNC = 2;
  localparam int SAT  = (1 << CW) - 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 3;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic clk = 1'b0;
  logic clr_n;

  pwm_capture_if #(.CW(CW)) bus ();

  pwm_capture #(
    .CW   (CW),
    .SYNC (SYNC)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hi[$];
  int exp_per[$];
  int duties[$];
  int armed    = 0;
  int prev_h   = 0;
  int prev_p   = 0;
  int held_hi  = 0;
  int held_per = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every valid must match the oldest outstanding expected measurement
  always @(negedge clk) begin
    if (clr_n && bus.valid === 1'b1) begin
      check("valid_expected", 32'(exp_hi.size() > 0), 1);
      if (exp_hi.size() > 0) begin
        int eh;
        int ep;
        eh = exp_hi.pop_front();
        ep = exp_per.pop_front();
        check("high_cnt", bus.high_cnt, eh);
        check("period_cnt", bus.period_cnt, ep);
      end
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Raise pwm_in; the previous period is expected only if it was aligned and fit the counter
  task automatic start_period(input int h, input int p);
    if (armed != 0 && prev_p <= SAT) begin
      exp_hi.push_back(prev_h);
      exp_per.push_back(prev_p);
      held_hi  = prev_h;
      held_per = prev_p;
    end
    armed      = 1;
    prev_h     = h;
    prev_p     = p;
    bus.pwm_in = 1'b1;
  endtask

  task automatic pwm_period(input int h, input int p, input bit lat_chk);
    start_period(h, p);
    if (lat_chk) begin
      for (int k = 1; k <= LAT; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("latency_edge%0d", k), bus.valid, 32'(k == LAT));
      end
      tick(h - LAT);
    end else begin
      tick(h);
    end
    bus.pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_high_cnt"}, bus.high_cnt, 0);
    check({tag, "_period_cnt"}, bus.period_cnt, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_level"}, bus.level, 0);
  endtask

  initial begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    duties = '{3, 128, 200, 253};
`else
    duties = '{1, 2, 128, 200, 254, 255};
`endif
    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;
    clr_n      = 1'b1;
    #2;
    clr_n = 1'b0;
    tick(3);
    check_zero_outputs("reset");

    clr_n  = 1'b1;
    bus.en = 1'b1;
    tick(2);

    // Loopback at period 255 (256 clocks), duty 64
    pwm_period(64, 256, 1'b0);
    pwm_period(64, 256, 1'b1);
    pwm_period(64, 256, 1'b0);
    pwm_period(64, 256, 1'b0);
    check("loopback_overflow", bus.overflow, 0);

    foreach (duties[i]) pwm_period(duties[i], 256, 1'b0);

    // Constant high after one rise: overflow 511 cycles after the reload
    start_period(1, 9999);
    tick(LAT + 510);
    check("ovf_high_before", bus.overflow, 0);
    tick(1);
    check("ovf_high_set", bus.overflow, 1);
    check("ovf_high_level", bus.level, 1);
    check("ovf_hold_high_cnt", bus.high_cnt, held_hi);
    check("ovf_hold_period_cnt", bus.period_cnt, held_per);
    bus.pwm_in = 1'b0;
    tick(20);
    pwm_period(30, 100, 1'b0);
    check("ovf_sticky_after_align", bus.overflow, 1);
    pwm_period(40, 100, 1'b0);
    check("ovf_cleared_by_valid", bus.overflow, 0);

    // Period of exactly 2^CW-1 is reported, 2^CW overflows
    pwm_period(100, SAT, 1'b0);
    pwm_period(50, SAT + 1, 1'b0);
    pwm_period(40, 100, 1'b0);
    check("ovf_period_too_long", bus.overflow, 1);
    pwm_period(40, 100, 1'b0);

    // Asynchronous reset in the middle of a high phase
    start_period(60, 9999);
    tick(20);
    #2;
    clr_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    bus.pwm_in = 1'b0;
    armed      = 0;
    tick(5);
    clr_n = 1'b1;
    tick(10);
    pwm_period(25, 90, 1'b0);
    pwm_period(25, 90, 1'b0);

    // Enable dropped for 100 cycles mid-measurement
    start_period(30, 9999);
    tick(20);
    bus.en     = 1'b0;
    armed      = 0;
    bus.pwm_in = 1'b0;
    tick(40);
    check("en_low_hold_high_cnt", bus.high_cnt, held_hi);
    check("en_low_hold_period_cnt", bus.period_cnt, held_per);
    bus.pwm_in = 1'b1;
    tick(30);
    check("en_low_level_high", bus.level, 1);
    bus.pwm_in = 1'b0;
    tick(30);
    check("en_low_level_low", bus.level, 0);
    check("en_low_hold_period_cnt2", bus.period_cnt, held_per);
    bus.en = 1'b1;
    tick(5);
    pwm_period(20, 80, 1'b0);
    pwm_period(20, 80, 1'b0);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // A 2-cycle low glitch inside a 100-cycle high phase is filtered out
    start_period(100, 200);
    tick(40);
    bus.pwm_in = 1'b0;
    tick(2);
    bus.pwm_in = 1'b1;
    tick(58);
    bus.pwm_in = 1'b0;
    tick(100);
    pwm_period(50, 150, 1'b1);
`endif

    // Line stuck low while measuring: overflow with level 0
    start_period(20, 9999);
    tick(20);
    bus.pwm_in = 1'b0;
    tick(LAT + 490);
    check("ovf_low_before", bus.overflow, 0);
    tick(1);
    check("ovf_low_set", bus.overflow, 1);
    check("ovf_low_level", bus.level, 0);

    tick(4);
    check("exp_drained", exp_hi.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
